// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop response checker.
package sr_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        UNK   = 2'b01,
        KNOWN = 2'b10
    } sr_state_t;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RST   = 2'b01;
    localparam logic [1:0] SR_SET   = 2'b10;
    localparam logic [1:0] SR_INV   = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_Q    = 2'b01;
    localparam logic [1:0] ERR_COMP = 2'b10;
    localparam logic [1:0] ERR_BOTH = 2'b11;

    // Encode the violation cause reported in err_code.
    function automatic logic [1:0] err_code_of(input logic q_err, input logic comp_err);
        logic [1:0] code;
        case ({comp_err, q_err})
            2'b01:   code = ERR_Q;
            2'b10:   code = ERR_COMP;
            2'b11:   code = ERR_BOTH;
            default: code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear to zero on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1'b1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/sr_checker.sv
// Response monitor for an SR flip-flop: runs a reference model one edge
// behind the applied inputs, flags q/complement violations and counts events.
module sr_checker
    import sr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    output logic             model_q,
    output logic             model_valid,
    output logic             mismatch,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cnt_set,
    output logic [CNT_W-1:0] cnt_reset,
    output logic [CNT_W-1:0] cnt_hold,
    output logic [CNT_W-1:0] cnt_invalid,
    output logic [CNT_W-1:0] cnt_fail
);

    sr_state_t  state_r;
    sr_state_t  state_s;
    logic       model_q_r;
    logic       model_q_s;
    logic       model_valid_r;
    logic [1:0] sr_d_r;
    logic       sr_d_vld_r;
    logic       q_err_s;
    logic       comp_err_s;
    logic       viol_s;
    logic       mismatch_r;
    logic       err_r;
    logic [1:0] err_code_r;
    logic       inc_set_s;
    logic       inc_reset_s;
    logic       inc_hold_s;
    logic       inc_invalid_s;

    // Capture the pair applied to the flip-flop so it can be judged next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_d_r     <= SR_HOLD;
            sr_d_vld_r <= 1'b0;
        end else begin
            sr_d_r     <= {s, r};
            sr_d_vld_r <= 1'b1;
        end
    end

    // Reference model next state: advance by the previously applied pair.
    always_comb begin
        state_s   = state_r;
        model_q_s = model_q_r;
        case (state_r)
            INIT: begin
                state_s = UNK;
            end
            UNK: begin
                case (sr_d_r)
                    SR_SET:  begin state_s = KNOWN; model_q_s = 1'b1; end
                    SR_RST:  begin state_s = KNOWN; model_q_s = 1'b0; end
                    default: state_s = UNK;
                endcase
            end
            KNOWN: begin
                case (sr_d_r)
                    SR_SET:  model_q_s = 1'b1;
                    SR_RST:  model_q_s = 1'b0;
                    SR_INV:  state_s   = UNK;
                    default: state_s   = KNOWN;
                endcase
            end
            default: begin
                state_s = INIT;
            end
        endcase
    end

    // Judge the DUT only when the updated model state is known.
    always_comb begin
        q_err_s    = 1'b0;
        comp_err_s = 1'b0;
        if ((state_s == KNOWN) && sr_d_vld_r) begin
            q_err_s    = (q != model_q_s);
            comp_err_s = (qbar == q);
        end else begin
            q_err_s    = 1'b0;
            comp_err_s = 1'b0;
        end
        viol_s = q_err_s | comp_err_s;
    end

    // Model state and per-cycle verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= INIT;
            model_q_r     <= 1'b0;
            model_valid_r <= 1'b0;
            mismatch_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            model_q_r     <= model_q_s;
            model_valid_r <= (state_s == KNOWN);
            mismatch_r    <= viol_s;
        end
    end

    // Sticky error flag; the first cause is kept until clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (clr) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (viol_s && !err_r) begin
            err_r      <= 1'b1;
            err_code_r <= err_code_of(q_err_s, comp_err_s);
        end else begin
            err_r      <= err_r;
            err_code_r <= err_code_r;
        end
    end

    assign inc_set_s     = sr_d_vld_r && (sr_d_r == SR_SET);
    assign inc_reset_s   = sr_d_vld_r && (sr_d_r == SR_RST);
    assign inc_hold_s    = sr_d_vld_r && (sr_d_r == SR_HOLD);
    assign inc_invalid_s = sr_d_vld_r && (sr_d_r == SR_INV);

    sat_counter #(.W(CNT_W)) u_cnt_set (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_set_s), .cnt(cnt_set)
    );
    sat_counter #(.W(CNT_W)) u_cnt_reset (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_reset_s), .cnt(cnt_reset)
    );
    sat_counter #(.W(CNT_W)) u_cnt_hold (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_hold_s), .cnt(cnt_hold)
    );
    sat_counter #(.W(CNT_W)) u_cnt_invalid (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_invalid_s), .cnt(cnt_invalid)
    );
    sat_counter #(.W(CNT_W)) u_cnt_fail (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(viol_s), .cnt(cnt_fail)
    );

    assign model_q     = model_q_r;
    assign model_valid = model_valid_r;
    assign mismatch    = mismatch_r;
    assign err         = err_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_sr_checker.sv
// Randomised bench for sr_checker: two instances (wide and 2-bit counters)
// share one stimulus stream and are compared against a behavioural model.
module tb_sr_checker;
    import sr_pkg::*;

    localparam int WA = 8;
    localparam int WB = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic s     = 1'b0;
    logic r     = 1'b0;
    logic q     = 1'b0;
    logic qbar  = 1'b1;

    logic          a_model_q, a_model_valid, a_mismatch, a_err;
    logic [1:0]    a_err_code;
    logic [WA-1:0] a_set, a_rst, a_hold, a_inv, a_fail;
    logic          b_model_q, b_model_valid, b_mismatch, b_err;
    logic [1:0]    b_err_code;
    logic [WB-1:0] b_set, b_rst, b_hold, b_inv, b_fail;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_first;
    bit       m_known;
    bit       m_val;
    bit       m_mis;
    bit       m_err;
    bit [1:0] m_code;
    bit [1:0] m_prev;
    int       ma[5];
    int       mb[5];
    bit       ff_q;

    always #5 clk = ~clk;

    sr_checker #(.CNT_W(WA)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
        .model_q(a_model_q), .model_valid(a_model_valid), .mismatch(a_mismatch),
        .err(a_err), .err_code(a_err_code), .cnt_set(a_set), .cnt_reset(a_rst),
        .cnt_hold(a_hold), .cnt_invalid(a_inv), .cnt_fail(a_fail)
    );

    sr_checker #(.CNT_W(WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
        .model_q(b_model_q), .model_valid(b_model_valid), .mismatch(b_mismatch),
        .err(b_err), .err_code(b_err_code), .cnt_set(b_set), .cnt_reset(b_rst),
        .cnt_hold(b_hold), .cnt_invalid(b_inv), .cnt_fail(b_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_first = 1'b1;
        m_known = 1'b0;
        m_val   = 1'b0;
        m_mis   = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'b00;
        m_prev  = 2'b00;
        for (int i = 0; i < 5; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    // Behaviour of one rising edge, expressed from the checking rules.
    task automatic model_step();
        bit qe, ce, v;
        int idx;
        qe = 1'b0; ce = 1'b0; v = 1'b0;
        if (m_first) begin
            m_first = 1'b0;
            m_known = 1'b0;
            m_mis   = 1'b0;
        end else begin
            if (m_prev == SR_SET) begin m_known = 1'b1; m_val = 1'b1; end
            else if (m_prev == SR_RST) begin m_known = 1'b1; m_val = 1'b0; end
            else if (m_prev == SR_INV) m_known = 1'b0;
            if (m_known) begin
                qe = (q != m_val);
                ce = (qbar == q);
                v  = qe | ce;
            end
            m_mis = v;
            if (clr) begin
                for (int i = 0; i < 5; i++) begin ma[i] = 0; mb[i] = 0; end
                m_err  = 1'b0;
                m_code = 2'b00;
            end else begin
                idx = (m_prev == SR_SET) ? 0 : (m_prev == SR_RST) ? 1 :
                      (m_prev == SR_HOLD) ? 2 : 3;
                ma[idx] = sat_inc(ma[idx], WA);
                mb[idx] = sat_inc(mb[idx], WB);
                if (v) begin
                    ma[4] = sat_inc(ma[4], WA);
                    mb[4] = sat_inc(mb[4], WB);
                    if (!m_err) begin
                        m_err  = 1'b1;
                        m_code = {ce, qe};
                    end
                end
            end
        end
        m_prev = {s, r};
    endtask

    task automatic check_all(input string ph);
        if (m_known) check({ph, ":model_q"}, a_model_q, m_val);
        check({ph, ":model_valid"}, a_model_valid, m_known);
        check({ph, ":mismatch"}, a_mismatch, m_mis);
        check({ph, ":err"}, a_err, m_err);
        check({ph, ":err_code"}, a_err_code, m_code);
        check({ph, ":cnt_set"}, a_set, ma[0]);
        check({ph, ":cnt_reset"}, a_rst, ma[1]);
        check({ph, ":cnt_hold"}, a_hold, ma[2]);
        check({ph, ":cnt_invalid"}, a_inv, ma[3]);
        check({ph, ":cnt_fail"}, a_fail, ma[4]);
        check({ph, ":b_mismatch"}, b_mismatch, m_mis);
        check({ph, ":b_err"}, b_err, m_err);
        check({ph, ":b_cnt_set"}, b_set, mb[0]);
        check({ph, ":b_cnt_reset"}, b_rst, mb[1]);
        check({ph, ":b_cnt_hold"}, b_hold, mb[2]);
        check({ph, ":b_cnt_invalid"}, b_inv, mb[3]);
        check({ph, ":b_cnt_fail"}, b_fail, mb[4]);
    endtask

    // fault: bit0 inverts q, bit1 forces qbar equal to q.
    task automatic cycle(input logic [1:0] sr, input int fault, input bit clr_v, input string ph);
        @(negedge clk);
        case ({s, r})
            SR_SET:  ff_q = 1'b1;
            SR_RST:  ff_q = 1'b0;
            SR_INV:  ff_q = 1'($urandom_range(0, 1));
            default: ff_q = ff_q;
        endcase
        q    = ff_q ^ fault[0];
        qbar = fault[1] ? q : ~q;
        s    = sr[1];
        r    = sr[0];
        clr  = clr_v;
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic mid_reset(input string ph);
        #2 rst_n = 1'b0;
        #1;
        check({ph, ":async_mismatch"}, a_mismatch, 1'b0);
        check({ph, ":async_valid"}, a_model_valid, 1'b0);
        check({ph, ":async_err"}, a_err, 1'b0);
        check({ph, ":async_cnt_hold"}, a_hold, 32'd0);
        check({ph, ":async_model_q"}, a_model_q, 1'b0);
        reset_model();
        ff_q = 1'b0;
        s    = 1'b0;
        r    = 1'b0;
        clr  = 1'b0;
        q    = 1'bx;
        qbar = 1'bx;
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        check_all({ph, ":first_edge"});
    endtask

    initial begin
        reset_model();
        ff_q = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Set then hold with a healthy flip-flop
        cycle(SR_SET, 0, 1'b0, "set_init");
        cycle(SR_HOLD, 0, 1'b0, "set_seen");
        // One of each pair
        cycle(SR_RST, 0, 1'b0, "seq_rst");
        cycle(SR_SET, 0, 1'b0, "seq_set");
        cycle(SR_INV, 0, 1'b0, "seq_inv");
        cycle(SR_HOLD, 0, 1'b0, "seq_after_inv");
        cycle(SR_HOLD, 0, 1'b0, "seq_settle");
        // q fault then complement fault
        cycle(SR_SET, 0, 1'b0, "f_set");
        cycle(SR_HOLD, 1, 1'b0, "f_q");
        cycle(SR_HOLD, 0, 1'b0, "f_clean");
        cycle(SR_HOLD, 2, 1'b0, "f_comp");
        cycle(SR_HOLD, 0, 1'b1, "f_clr");
        cycle(SR_HOLD, 2, 1'b0, "comp_first");
        cycle(SR_HOLD, 0, 1'b1, "clr2");
        cycle(SR_HOLD, 3, 1'b0, "both_first");
        // Saturate the narrow counters, then clear with a fault in the same cycle
        for (int i = 0; i < 7; i++) cycle(SR_HOLD, 0, 1'b0, "hold_sat");
        cycle(SR_HOLD, 1, 1'b1, "clr_drop");
        cycle(SR_HOLD, 0, 1'b0, "after_clr");
        // Asynchronous reset between edges
        cycle(SR_SET, 0, 1'b0, "pre_rst");
        mid_reset("midrst");
        cycle(SR_HOLD, 0, 1'b0, "post_rst");

        // Random traffic with occasional faults and clears
        for (int i = 0; i < 400; i++) begin
            int f;
            f = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
            cycle(2'($urandom_range(0, 3)), f, ($urandom_range(0, 39) == 0), "rand");
        end
        mid_reset("midrst2");
        for (int i = 0; i < 100; i++) begin
            cycle(2'($urandom_range(0, 3)), 0, 1'b0, "rand2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
